clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 113 +++++++++++
 rtl/clk_div_prog.sv | 38 +++
 tb/tb_clk_div_prog.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
// Strobe generation is built only when CLK_DIV_PROG_STROBE_EN is defined.
package clk_div_pkg;

    // Default channel count and divisor width.
    localparam int unsigned N_CH_DEF  = 2;
    localparam int unsigned DIV_W_DEF = 8;

    // Largest supported number of channels.
    localparam int unsigned MAX_CH    = 8;

    // Per-channel run flags kept together in one register.
    typedef struct packed {
        logic active;
        logic clk;
    } chan_flags_t;

endpackage : clk_div_pkg

// File: rtl/clk_div_chan.sv
// One divided-clock channel: half-period counter, latched divisor and
// run/stop handling. The divisor is re-latched only at a 1->0 toggle,
// at start-up or on sync, so a divisor write never alters a running period.
// Strobe registers exist only with CLK_DIV_PROG_STROBE_EN defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             active
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    chan_flags_t      flags_q;
    chan_flags_t      flags_d;
    logic             rise_d;
    logic             fall_d;

    // Next-state: sync beats everything, then start, stop, toggle, count.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        flags_d = flags_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync && en) begin
            // Re-phase: forced low without a fall strobe.
            cnt_d          = '0;
            div_d          = div;
            flags_d.clk    = 1'b0;
            flags_d.active = 1'b1;
        end else if (!flags_q.active) begin
            cnt_d       = '0;
            flags_d.clk = 1'b0;
            if (en) begin
                flags_d.active = 1'b1;
                div_d          = div;
            end
        end else if (!en && !flags_q.clk) begin
            // Stopping while low ends at once; no partial pulse is possible.
            flags_d.active = 1'b0;
            cnt_d          = '0;
        end else if (cnt_q == div_q) begin
            cnt_d       = '0;
            flags_d.clk = ~flags_q.clk;
            if (flags_q.clk) begin
                // Period boundary: pick up a new divisor, finish a pending stop.
                fall_d = 1'b1;
                div_d  = div;
                if (!en) begin
                    flags_d.active = 1'b0;
                end
            end else begin
                rise_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter, divisor and flag registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            flags_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            flags_q <= flags_d;
        end
    end

    assign clk_out = flags_q.clk;
    assign active  = flags_q.active;

`ifdef CLK_DIV_PROG_STROBE_EN
    logic rise_q;
    logic fall_q;

    // Edge strobes registered alongside the clock they describe.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
`else
    // Strobes disabled: outputs tied low, edge decodes left unused.
    logic unused_stb;
    assign unused_stb = rise_d ^ fall_d;
    assign rise_stb   = 1'b0;
    assign fall_stb   = 1'b0;
`endif

endmodule : clk_div_chan

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider top: slices the divisor bus and
// fans sync out to N_CH independent clk_div_chan instances (N_CH in 1..MAX_CH).
// Optional strobe outputs are controlled by CLK_DIV_PROG_STROBE_EN.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH*DIV_W-1:0] div,
    input  logic                  sync,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       rise_stb,
    output logic [N_CH-1:0]       fall_stb,
    output logic [N_CH-1:0]       active
);

    // One channel per divided clock; channel k uses div[k*DIV_W +: DIV_W].
    for (genvar k = 0; k < int'(N_CH); k++) begin : g_chan
        clk_div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (en[k]),
            .sync     (sync),
            .div      (div[k*DIV_W +: DIV_W]),
            .clk_out  (clk_out[k]),
            .rise_stb (rise_stb[k]),
            .fall_stb (fall_stb[k]),
            .active   (active[k])
        );
    end

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (N_CH=2, DIV_W=8, 50 MHz).
// Expected strobe values follow CLK_DIV_PROG_STROBE_EN.
module tb_clk_div_prog;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned DIV_W = 8;
`ifdef CLK_DIV_PROG_STROBE_EN
    localparam int STB = 1;
`else
    localparam int STB = 0;
`endif

    logic                  clk_in = 1'b0;
    logic                  rst    = 1'b1;
    logic [N_CH-1:0]       en     = '0;
    logic [N_CH*DIV_W-1:0] div    = '0;
    logic                  sync   = 1'b0;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       rise_stb;
    logic [N_CH-1:0]       fall_stb;
    logic [N_CH-1:0]       active;

    int n_checks = 0;
    int n_pass   = 0;
    int rise_seen [N_CH];
    int fall_seen [N_CH];
    int both_seen = 0;
    int n;

    clk_div_prog #(
        .N_CH  (N_CH),
        .DIV_W (DIV_W)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .sync     (sync),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .active   (active)
    );

    // 50 MHz source clock.
    always #10 clk_in = ~clk_in;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clk_in cycle, sample 1 ns after the edge, tally strobes.
    task automatic tick();
        @(posedge clk_in);
        #1;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (rise_stb[k]) rise_seen[k]++;
            if (fall_stb[k]) fall_seen[k]++;
        end
        if ((rise_stb & fall_stb) != '0) both_seen++;
    endtask

    task automatic clear_seen();
        for (int k = 0; k < int'(N_CH); k++) begin
            rise_seen[k] = 0;
            fall_seen[k] = 0;
        end
        both_seen = 0;
    endtask

    // Cycles until clk_out[ch] reaches lvl; -1 when the budget runs out.
    task automatic wait_level(input int ch, input logic lvl, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (clk_out[ch] != lvl && cyc < max_cyc);
        if (clk_out[ch] != lvl) cyc = -1;
    endtask

    initial begin
        clear_seen();

        // Reset state.
        #5;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_active", int'(active), 0);
        check("rst_rise_stb", int'(rise_stb), 0);
        check("rst_fall_stb", int'(fall_stb), 0);

        // ch0 div=2: 6-cycle period (120 ns), 3 high / 3 low.
        tick();
        div[0 +: DIV_W] = 8'd2;
        en = 2'b01;
        rst = 1'b0;
        tick();
        check("start_active", int'(active), 1);
        clear_seen();
        wait_level(0, 1'b1, 20, n);
        check("first_rise_delay", n, 3);
        check("rise_stb_coincident", int'(rise_stb[0]), STB);
        wait_level(0, 1'b0, 20, n);
        check("high_cycles", n, 3);
        check("fall_stb_coincident", int'(fall_stb[0]), STB);
        wait_level(0, 1'b1, 20, n);
        check("low_cycles", n, 3);
        check("rise_count", rise_seen[0], 2 * STB);
        check("fall_count", fall_seen[0], STB);
        check("no_dual_strobe", both_seen, 0);
        check("ch1_idle", int'(clk_out[1]), 0);

        // Divisor 2 -> 5 written mid-high: this high phase unchanged, next period 12.
        tick();
        div[0 +: DIV_W] = 8'd5;
        wait_level(0, 1'b0, 20, n);
        check("midhigh_rest", n, 2);
        wait_level(0, 1'b1, 20, n);
        check("new_low", n, 6);
        wait_level(0, 1'b0, 20, n);
        check("new_high", n, 6);

        // div=3 latched at next fall; drop en one cycle after the rise.
        div[0 +: DIV_W] = 8'd3;
        wait_level(0, 1'b1, 20, n);
        check("div5_low", n, 6);
        wait_level(0, 1'b0, 20, n);
        check("div5_high", n, 6);
        wait_level(0, 1'b1, 20, n);
        check("div3_low", n, 4);
        tick();
        en = 2'b00;
        clear_seen();
        wait_level(0, 1'b0, 20, n);
        check("stop_high_rest", n, 3);
        check("stop_active", int'(active[0]), 0);
        check("stop_fall_count", fall_seen[0], STB);
        for (int i = 0; i < 5; i++) tick();
        check("stop_stays_low", int'(clk_out), 0);
        check("stop_stays_idle", int'(active), 0);

        // Sync with ch0 div=0, ch1 div=255.
        div[0 +: DIV_W] = 8'd0;
        div[DIV_W +: DIV_W] = 8'd255;
        en = 2'b11;
        tick();
        check("both_active", int'(active), 3);
        for (int i = 0; i < 5; i++) tick();
        check("ch0_high_before_sync", int'(clk_out[0]), 1);
        sync = 1'b1;
        clear_seen();
        tick();
        sync = 1'b0;
        check("sync_low", int'(clk_out), 0);
        check("sync_active", int'(active), 3);
        tick();
        check("sync_ch0_rise", int'(clk_out[0]), 1);
        check("sync_ch1_low", int'(clk_out[1]), 0);
        check("sync_ch0_rise_stb", rise_seen[0], STB);
        check("sync_no_fall", fall_seen[0] + fall_seen[1], 0);
        wait_level(1, 1'b1, 300, n);
        check("sync_ch1_rise", n, 255);

        // Asynchronous reset during ch1 high phase, then restart.
        tick();
        #4;
        rst = 1'b1;
        #1;
        check("arst_clk_out", int'(clk_out), 0);
        check("arst_active", int'(active), 0);
        check("arst_strobes", int'(rise_stb | fall_stb), 0);
        div[0 +: DIV_W] = 8'd4;
        tick();
        tick();
        check("arst_held", int'(clk_out | active), 0);
        #3;
        rst = 1'b0;
        tick();
        check("restart_active", int'(active), 3);
        check("restart_low", int'(clk_out), 0);
        wait_level(0, 1'b1, 20, n);
        check("restart_rise", n, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clk_div_prog
